// File: rtl/bel_avl_ram_arb.sv
// Two-master Avalon-MM arbiter in front of the FFT working RAM. Commands pass
// through combinationally; an in-order owner FIFO steers read data back.
module bel_avl_ram_arb #(
  parameter int adr_width   = 6,
  parameter int dwidth      = 32,
  parameter int max_pending = 4,
  parameter int fixed_prio  = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [adr_width-1:0]          m0_address,
  input  logic                          m0_read,
  input  logic                          m0_write,
  input  logic [dwidth-1:0]             m0_writedata,
  output logic                          m0_waitrequest,
  output logic [dwidth-1:0]             m0_readdata,
  output logic                          m0_readdatavalid,
  input  logic [adr_width-1:0]          m1_address,
  input  logic                          m1_read,
  input  logic                          m1_write,
  input  logic [dwidth-1:0]             m1_writedata,
  output logic                          m1_waitrequest,
  output logic [dwidth-1:0]             m1_readdata,
  output logic                          m1_readdatavalid,
  output logic [adr_width-1:0]          s_address,
  output logic                          s_read,
  output logic                          s_write,
  output logic [dwidth-1:0]             s_writedata,
  input  logic [dwidth-1:0]             s_readdata,
  input  logic                          s_readdatavalid,
  output logic [$clog2(max_pending):0]  pending_o,
  output logic                          err_o
);

  localparam int pw = $clog2(max_pending);

  typedef logic [pw-1:0] ptr_t;
  typedef logic [pw:0]   cnt_t;

  logic                   req0, req1;
  logic                   full, empty;
  logic                   elig0, elig1;
  logic                   gnt0, gnt1;
  logic                   push, pop;
  logic                   head_owner;
  logic                   last_grant_q;
  logic                   err_q;
  logic [max_pending-1:0] owner_q;
  ptr_t                   wr_ptr_q, rd_ptr_q;
  cnt_t                   count_q;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign full  = (count_q == cnt_t'(max_pending));
  assign empty = (count_q == '0);

  // A read needs a free owner slot this cycle; a same-cycle pop does not count.
  assign elig0 = rst_n_i & (m0_read ? ~full : m0_write);
  assign elig1 = rst_n_i & (m1_read ? ~full : m1_write);

  // last_grant_q == 1 means master 1 went last, so master 0 takes the tie.
  assign gnt0 = elig0 & (~elig1 | (fixed_prio != 0) | last_grant_q);
  assign gnt1 = elig1 & ~gnt0;

  assign m0_waitrequest = ~rst_n_i | (req0 & ~gnt0);
  assign m1_waitrequest = ~rst_n_i | (req1 & ~gnt1);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    s_address   = m0_address;
    s_writedata = m0_writedata;
    s_read      = gnt0 & m0_read;
    s_write     = gnt0 & m0_write;
    if (gnt1) begin
      s_address   = m1_address;
      s_writedata = m1_writedata;
      s_read      = m1_read;
      s_write     = m1_write;
    end
  end

  assign push       = s_read;
  assign pop        = rst_n_i & s_readdatavalid & ~empty;
  assign head_owner = owner_q[rd_ptr_q];

  assign m0_readdatavalid = pop & ~head_owner;
  assign m1_readdatavalid = pop & head_owner;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;

  assign pending_o = count_q;
  assign err_o     = err_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      if (gnt0 | gnt1) last_grant_q <= gnt1;
      if (push)        wr_ptr_q     <= wr_ptr_q + 1'b1;
      if (pop)         rd_ptr_q     <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (s_readdatavalid & empty) err_q <= 1'b1;
    end
  end

  // NOTE: owner storage is not reset; count_q says which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) owner_q[wr_ptr_q] <= gnt1;
  end

endmodule

// File: tb/tb_bel_avl_ram_arb.sv
// Bench for bel_avl_ram_arb: cycle scoreboard against an owner-queue model,
// a latency-queue RAM slave, and one task per scenario.
module tb_bel_avl_ram_arb;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int MP = 4;
  localparam int PW = $clog2(MP);

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;

  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic          m0_rd = 1'b0, m1_rd = 1'b0, m0_wr = 1'b0, m1_wr = 1'b0;
  logic [DW-1:0] m0_wd = '0, m1_wd = '0;
  logic          m0_wait, m1_wait, m0_rdv, m1_rdv;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] s_address;
  logic          s_read, s_write;
  logic [DW-1:0] s_writedata;
  logic [DW-1:0] s_rdata = '0;
  logic          s_rdv = 1'b0;
  logic [PW:0]   pending_o;
  logic          err_o;

  logic          f_m0_wait, f_m1_wait, f_m0_rdv, f_m1_rdv;
  logic [DW-1:0] f_m0_rdata, f_m1_rdata;
  logic [AW-1:0] f_s_address;
  logic          f_s_read, f_s_write;
  logic [DW-1:0] f_s_writedata;
  logic [PW:0]   f_pending;
  logic          f_err;

  int n_checks = 0;
  int n_pass   = 0;

  bel_avl_ram_arb #(.adr_width(AW), .dwidth(DW), .max_pending(MP), .fixed_prio(0)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_address(m0_addr), .m0_read(m0_rd), .m0_write(m0_wr), .m0_writedata(m0_wd),
    .m0_waitrequest(m0_wait), .m0_readdata(m0_rdata), .m0_readdatavalid(m0_rdv),
    .m1_address(m1_addr), .m1_read(m1_rd), .m1_write(m1_wr), .m1_writedata(m1_wd),
    .m1_waitrequest(m1_wait), .m1_readdata(m1_rdata), .m1_readdatavalid(m1_rdv),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_readdata(s_rdata), .s_readdatavalid(s_rdv),
    .pending_o(pending_o), .err_o(err_o)
  );

  bel_avl_ram_arb #(.adr_width(AW), .dwidth(DW), .max_pending(MP), .fixed_prio(1)) dut_fixed (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_address(m0_addr), .m0_read(m0_rd), .m0_write(m0_wr), .m0_writedata(m0_wd),
    .m0_waitrequest(f_m0_wait), .m0_readdata(f_m0_rdata), .m0_readdatavalid(f_m0_rdv),
    .m1_address(m1_addr), .m1_read(m1_rd), .m1_write(m1_wr), .m1_writedata(m1_wd),
    .m1_waitrequest(f_m1_wait), .m1_readdata(f_m1_rdata), .m1_readdatavalid(f_m1_rdv),
    .s_address(f_s_address), .s_read(f_s_read), .s_write(f_s_write), .s_writedata(f_s_writedata),
    .s_readdata(s_rdata), .s_readdatavalid(s_rdv),
    .pending_o(f_pending), .err_o(f_err)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: outstanding reads in issue order, last winner, error flag.
  typedef struct { int owner; logic [DW-1:0] data; } rd_t;
  typedef struct { int due; logic [DW-1:0] data; } sr_t;
  typedef struct { int m; int cyc; bit rd; bit wr; } acc_t;
  typedef struct { int m; int cyc; logic [DW-1:0] data; } rdv_t;

  rd_t           own_q[$];
  sr_t           slv_q[$];
  acc_t          acc_log[$];
  rdv_t          rdv_log[$];
  logic [DW-1:0] mem [64];
  int            model_last = 1;
  bit            model_err  = 1'b0;
  int            cyc        = 0;
  int            last_due   = 0;
  int            lat_min    = 1;
  int            lat_max    = 1;
  int            pend_max   = 0;
  bit            inj_valid  = 1'b0;

  function automatic void model_clear();
    own_q.delete();
    slv_q.delete();
    model_last = 1;
    model_err  = 1'b0;
    last_due   = 0;
    inj_valid  = 1'b0;
  endfunction

  // RAM slave: in-order responses after a bounded random latency.
  always @(posedge clk_i) begin
    #1;
    cyc++;
    if (!rst_n_i) begin
      slv_q.delete();
      s_rdv = 1'b0;
    end else if (inj_valid) begin
      s_rdv     = 1'b1;
      s_rdata   = $urandom;
      inj_valid = 1'b0;
    end else if (slv_q.size() > 0 && slv_q[0].due == cyc) begin
      s_rdv   = 1'b1;
      s_rdata = slv_q[0].data;
      void'(slv_q.pop_front());
    end else begin
      s_rdv   = 1'b0;
      s_rdata = $urandom;
    end
  end

  logic          rq_rd [2], rq_wr [2], got_wait [2], got_rdv [2];
  logic [AW-1:0] rq_a [2];
  logic [DW-1:0] rq_d [2], got_rdata [2];
  bit            elig [2];
  bit            full, exp_b, win_rd, win_wr;
  int            win, exp_own, due;

  // Scoreboard: predict this cycle's handshake from the model, then commit it.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      rq_rd = '{m0_rd, m1_rd};   rq_wr = '{m0_wr, m1_wr};
      rq_a  = '{m0_addr, m1_addr}; rq_d = '{m0_wd, m1_wd};
      got_wait  = '{m0_wait, m1_wait};
      got_rdv   = '{m0_rdv, m1_rdv};
      got_rdata = '{m0_rdata, m1_rdata};
      full = (own_q.size() == MP);
      for (int i = 0; i < 2; i++) elig[i] = (rq_rd[i] || rq_wr[i]) && !(rq_rd[i] && full);
      if (elig[0] && elig[1]) win = (model_last == 0) ? 1 : 0;
      else if (elig[0])       win = 0;
      else if (elig[1])       win = 1;
      else                    win = -1;
      win_rd = (win >= 0) ? rq_rd[win] : 1'b0;
      win_wr = (win >= 0) ? rq_wr[win] : 1'b0;

      for (int i = 0; i < 2; i++) begin
        exp_b = (rq_rd[i] || rq_wr[i]) && (win != i);
        n_checks++;
        if (got_wait[i] !== exp_b) $display("FAIL waitrequest%0d cyc=%0d got=%b exp=%b", i, cyc, got_wait[i], exp_b);
        else n_pass++;
      end
      n_checks++;
      if (s_read !== win_rd || s_write !== win_wr)
        $display("FAIL s_cmd cyc=%0d got rd=%b wr=%b exp rd=%b wr=%b", cyc, s_read, s_write, win_rd, win_wr);
      else n_pass++;
      if (win >= 0) begin
        n_checks++;
        if (s_address !== rq_a[win]) $display("FAIL s_address cyc=%0d got=%h exp=%h", cyc, s_address, rq_a[win]);
        else n_pass++;
        if (win_wr) begin
          n_checks++;
          if (s_writedata !== rq_d[win]) $display("FAIL s_writedata cyc=%0d got=%h exp=%h", cyc, s_writedata, rq_d[win]);
          else n_pass++;
        end
      end
      n_checks++;
      if (pending_o !== (PW+1)'(own_q.size())) $display("FAIL pending cyc=%0d got=%0d exp=%0d", cyc, pending_o, own_q.size());
      else n_pass++;
      n_checks++;
      if (err_o !== model_err) $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err_o, model_err);
      else n_pass++;

      exp_own = (s_rdv && own_q.size() > 0) ? own_q[0].owner : -1;
      for (int i = 0; i < 2; i++) begin
        exp_b = (exp_own == i);
        n_checks++;
        if (got_rdv[i] !== exp_b) $display("FAIL readdatavalid%0d cyc=%0d got=%b exp=%b", i, cyc, got_rdv[i], exp_b);
        else n_pass++;
        if (exp_b) begin
          n_checks++;
          if (got_rdata[i] !== own_q[0].data) $display("FAIL readdata%0d cyc=%0d got=%h exp=%h", i, cyc, got_rdata[i], own_q[0].data);
          else n_pass++;
        end
      end

      if (exp_own >= 0) begin
        rdv_log.push_back('{exp_own, cyc, got_rdata[exp_own]});
        void'(own_q.pop_front());
      end else if (s_rdv) begin
        model_err = 1'b1;
      end
      if (win >= 0) begin
        acc_log.push_back('{win, cyc, win_rd, win_wr});
        model_last = win;
        if (win_rd) own_q.push_back('{win, mem[rq_a[win]]});
      end
      if (own_q.size() > pend_max) pend_max = own_q.size();

      if (s_read === 1'b1) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        slv_q.push_back('{due, mem[s_address]});
      end
      if (s_write === 1'b1) mem[s_address] = s_writedata;
    end
  end

  task automatic drive(input int m, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin m0_rd = rd; m0_wr = wr; m0_addr = a; m0_wd = d; end
    else        begin m1_rd = rd; m1_wr = wr; m1_addr = a; m1_wd = d; end
  endtask

  // Issue one command at posedge+1 and hold it until accepted; returns stall count.
  task automatic m_cmd(input int m, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int waited);
    bit done = 1'b0;
    waited = 0;
    drive(m, rd, wr, a, d);
    while (!done) begin
      @(negedge clk_i);
      if (((m == 0) ? m0_wait : m1_wait) === 1'b0) done = 1'b1;
      else begin
        waited++;
        if (waited > 200) begin
          n_checks++;
          $display("FAIL accept_timeout m%0d waited=%0d required=accept", m, waited);
          drive(m, 1'b0, 1'b0, a, d);
          return;
        end
      end
    end
    @(posedge clk_i); #1;
    drive(m, 1'b0, 1'b0, a, d);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    model_clear();
    s_rdv = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    acc_log.delete();
    rdv_log.delete();
    pend_max = 0;
  endtask

  task automatic test_reset();
    drive(0, 1'b1, 1'b0, 6'd3, '0);
    drive(1, 1'b0, 1'b1, 6'd4, 32'h1234);
    #3;
    n_checks++;
    if (m0_wait !== 1'b1 || m1_wait !== 1'b1) $display("FAIL reset_wait got=%b%b exp=11", m0_wait, m1_wait);
    else n_pass++;
    n_checks++;
    if (s_read !== 1'b0 || s_write !== 1'b0) $display("FAIL reset_scmd got=%b%b exp=00", s_read, s_write);
    else n_pass++;
    n_checks++;
    if (pending_o !== '0 || err_o !== 1'b0) $display("FAIL reset_state got pend=%0d err=%b exp 0/0", pending_o, err_o);
    else n_pass++;
    n_checks++;
    if (m0_rdv !== 1'b0 || m1_rdv !== 1'b0) $display("FAIL reset_rdv got=%b%b exp=00", m0_rdv, m1_rdv);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_single_read();
    int w;
    do_reset();
    lat_min = 1; lat_max = 1;
    m_cmd(0, 1'b0, 1'b1, 6'd5, 32'hA5A5_0001, w);
    n_checks++;
    if (w != 0) $display("FAIL single_write_stall got=%0d exp=0", w); else n_pass++;
    m_cmd(0, 1'b1, 1'b0, 6'd5, '0, w);
    n_checks++;
    if (w != 0) $display("FAIL single_read_stall got=%0d exp=0", w); else n_pass++;
    repeat (5) @(posedge clk_i);
    #1;
    n_checks++;
    if (rdv_log.size() != 1 || acc_log.size() != 2) $display("FAIL single_counts got rdv=%0d acc=%0d exp 1/2", rdv_log.size(), acc_log.size());
    else begin
      n_pass++;
      n_checks++;
      if (rdv_log[0].m != 0 || rdv_log[0].data !== 32'hA5A5_0001)
        $display("FAIL single_data got m%0d %h exp m0 a5a50001", rdv_log[0].m, rdv_log[0].data);
      else n_pass++;
      n_checks++;
      if (rdv_log[0].cyc != acc_log[1].cyc + 1) $display("FAIL single_latency got=%0d exp=1", rdv_log[0].cyc - acc_log[1].cyc);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    int w0, w1;
    do_reset();
    lat_min = 1; lat_max = 1;
    fork
      begin m_cmd(0, 1'b1, 1'b0, 6'd1, '0, w0); m_cmd(0, 1'b1, 1'b0, 6'd1, '0, w0); end
      begin m_cmd(1, 1'b1, 1'b0, 6'd2, '0, w1); m_cmd(1, 1'b1, 1'b0, 6'd2, '0, w1); end
    join
    repeat (5) @(posedge clk_i);
    #1;
    n_checks++;
    if (acc_log.size() != 4 || rdv_log.size() != 4) $display("FAIL rr_counts got acc=%0d rdv=%0d exp 4/4", acc_log.size(), rdv_log.size());
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (acc_log[i].m != i % 2 || rdv_log[i].m != i % 2 || acc_log[i].cyc != acc_log[0].cyc + i)
          $display("FAIL rr_order%0d got acc=m%0d@%0d rdv=m%0d exp m%0d@%0d", i, acc_log[i].m, acc_log[i].cyc, rdv_log[i].m, i % 2, acc_log[0].cyc + i);
        else n_pass++;
      end
    end
    n_checks++;
    if (pend_max > 2) $display("FAIL rr_pending_peak got=%0d exp<=2", pend_max); else n_pass++;
  endtask

  task automatic test_fixed_prio();
    int nw = 0;
    logic [AW-1:0] a_exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_exp = AW'(10 + i);
      drive(0, 1'b0, 1'b1, a_exp, $urandom);
      drive(1, 1'b0, 1'b1, 6'd40, $urandom);
      @(negedge clk_i);
      n_checks++;
      if (f_m1_wait !== 1'b1 || f_m0_wait !== 1'b0) $display("FAIL fixed_wait%0d got m0=%b m1=%b exp 0/1", i, f_m0_wait, f_m1_wait);
      else n_pass++;
      n_checks++;
      if (f_s_write !== 1'b1 || f_s_address !== a_exp) $display("FAIL fixed_cmd%0d got wr=%b a=%h exp 1/%h", i, f_s_write, f_s_address, a_exp);
      else begin n_pass++; nw++; end
      @(posedge clk_i); #1;
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (nw != 4) $display("FAIL fixed_m0_writes got=%0d exp=4", nw); else n_pass++;
  endtask

  task automatic test_fifo_full();
    int w [5];
    int w0, r5_cyc, m0_cyc, nr;
    do_reset();
    lat_min = 6; lat_max = 6;
    fork
      for (int i = 0; i < 5; i++) m_cmd(1, 1'b1, 1'b0, AW'(20 + i), '0, w[i]);
      begin repeat (5) @(posedge clk_i); #1; m_cmd(0, 1'b0, 1'b1, 6'd30, $urandom, w0); end
    join
    repeat (15) @(posedge clk_i);
    #1;
    r5_cyc = -1; m0_cyc = -1; nr = 0;
    foreach (acc_log[i]) begin
      if (acc_log[i].m == 1) begin nr++; if (nr == 5) r5_cyc = acc_log[i].cyc; end
      else m0_cyc = acc_log[i].cyc;
    end
    n_checks++;
    if (rdv_log.size() != 5 || r5_cyc < 0) $display("FAIL full_counts got rdv=%0d reads=%0d exp 5/5", rdv_log.size(), nr);
    else begin
      n_pass++;
      n_checks++;
      if (r5_cyc != rdv_log[0].cyc + 1) $display("FAIL full_release got=%0d exp=%0d", r5_cyc, rdv_log[0].cyc + 1);
      else n_pass++;
      n_checks++;
      if (w[4] != 3) $display("FAIL full_stall got=%0d exp=3", w[4]); else n_pass++;
      n_checks++;
      if (m0_cyc < 0 || m0_cyc >= r5_cyc || w0 != 0) $display("FAIL full_m0_write got cyc=%0d stall=%0d exp before %0d, 0", m0_cyc, w0, r5_cyc);
      else n_pass++;
    end
    n_checks++;
    if (pend_max != 4) $display("FAIL full_pending_peak got=%0d exp=4", pend_max); else n_pass++;
  endtask

  task automatic test_unexpected_valid();
    do_reset();
    @(negedge clk_i);
    inj_valid = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if (err_o !== 1'b1 || rdv_log.size() != 0) $display("FAIL unexp_set got err=%b rdv=%0d exp 1/0", err_o, rdv_log.size());
    else n_pass++;
    repeat (5) @(posedge clk_i);
    #1;
    n_checks++;
    if (err_o !== 1'b1) $display("FAIL unexp_sticky got=%b exp=1", err_o); else n_pass++;
    do_reset();
    n_checks++;
    if (err_o !== 1'b0) $display("FAIL unexp_clear got=%b exp=0", err_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    lat_min = 6; lat_max = 6;
    for (int i = 0; i < 3; i++) m_cmd(0, 1'b1, 1'b0, AW'(i), '0, w);
    n_checks++;
    if (pending_o !== 3'd3) $display("FAIL mid_pending_before got=%0d exp=3", pending_o); else n_pass++;
    drive(0, 1'b1, 1'b0, 6'd7, '0);
    drive(1, 1'b1, 1'b0, 6'd8, '0);
    rst_n_i = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (pending_o !== '0) $display("FAIL mid_pending_async got=%0d exp=0", pending_o); else n_pass++;
    n_checks++;
    if (m0_wait !== 1'b1 || m1_wait !== 1'b1 || s_read !== 1'b0) $display("FAIL mid_in_reset got w=%b%b rd=%b exp 11/0", m0_wait, m1_wait, s_read);
    else n_pass++;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (m0_wait !== 1'b0 || m1_wait !== 1'b1 || s_address !== 6'd7) $display("FAIL mid_first_tie got w=%b%b a=%h exp 01/07", m0_wait, m1_wait, s_address);
    else n_pass++;
    @(posedge clk_i); #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk_i); #1;
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (10) @(posedge clk_i);
    #1;
  endtask

  task automatic master_random(input int m, input int n);
    int w, k;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(3, 0);
      if (k == 3) begin
        repeat ($urandom_range(2, 0)) begin @(posedge clk_i); #1; end
      end else begin
        m_cmd(m, k != 1, k != 0, AW'($urandom_range(63, 0)), $urandom, w);
      end
    end
  endtask

  task automatic test_random();
    int nrd = 0;
    do_reset();
    lat_min = 1; lat_max = 4;
    fork
      master_random(0, 60);
      master_random(1, 60);
    join
    repeat (20) @(posedge clk_i);
    #1;
    foreach (acc_log[i]) if (acc_log[i].rd) nrd++;
    n_checks++;
    if (rdv_log.size() != nrd) $display("FAIL random_returns got=%0d exp=%0d", rdv_log.size(), nrd); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_prio();
    test_fifo_full();
    test_unexpected_valid();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bel_avl_ram_arb.md
Name: bel_avl_ram_arb

Overview:
Two-master arbiter that shares one Avalon-MM RAM slave port between the FFT engine (master 0) and the host/DMA loader (master 1).
- Selects one requester per cycle, round-robin by default or fixed priority by parameter.
- Passes the winning command combinationally to the slave.
- Records the owner of each accepted read in an in-order FIFO, so that slave readdatavalid is returned to the correct master.
- Sits directly in front of the FFT working RAM.

Parameters:
adr_width, 6, address width on all ports.
dwidth, 32, data width on all ports (set equal to the FFT data-width define).
max_pending, 4, depth of the read-owner FIFO, i.e. maximum outstanding reads; power of two, at least 2.
fixed_prio, 0, 0 selects round-robin; 1 makes master 0 always win.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_n_i  in  1  asynchronous active-low reset.
m0_address  in  adr_width  master 0 word address.
m0_read  in  1  master 0 read request; held until accepted.
m0_write  in  1  master 0 write request; held until accepted.
m0_writedata  in  dwidth  master 0 write data.
m0_waitrequest  out  1  1 = master 0 command not accepted this cycle.
m0_readdata  out  dwidth  read data to master 0.
m0_readdatavalid  out  1  read data valid for master 0.
m1_*  same seven signals as m0_*, for master 1.
s_address  out  adr_width  address to the RAM slave.
s_read  out  1  read strobe to the slave.
s_write  out  1  write strobe to the slave.
s_writedata  out  dwidth  write data to the slave.
s_readdata  in  dwidth  slave read data.
s_readdatavalid  in  1  slave read data valid; arrives one or more cycles after s_read.
pending_o  out  log2(max_pending)+1  number of outstanding reads.
err_o  out  1  sticky flag: unexpected s_readdatavalid.

Behaviour:
- Request definitions:
  - reqN = mN_read | mN_write.
  - A read-carrying request (mN_read=1) is eligible only when the FIFO is not full.
  - A write-only request is always eligible.
  - Full blocks a read even if a pop happens in the same cycle; there is no bypass.
- Grant (combinational):
  - Grant goes to the eligible requester. If both are eligible:
    - fixed_prio=1: master 0 wins.
    - fixed_prio=0: the master other than last_grant wins.
  - No eligible requester: s_read = s_write = 0; s_address and s_writedata are don't-care, driven from master 0.
- Accepted command:
  - The granted master's address, read, write and writedata drive the slave in the same cycle.
  - Its mN_waitrequest = 0; the command counts as accepted at that clock edge.
- Stalled command: any requester not granted sees mN_waitrequest = 1.
- Idle master: mN_waitrequest = 0 when the master has no request.
- last_grant register: updates to the granted master index on every accepted command, read or write.
- Read-and-write together: a master asserting both in one command has both forwarded to the slave. The FIFO entry is pushed because read=1.
- Owner FIFO:
  - On an accepted read, push the owner index.
  - On s_readdatavalid, pop the head and raise m<head>_readdatavalid = 1 combinationally; the other master's readdatavalid = 0.
  - Push and pop in the same cycle leave pending_o unchanged; the head advances and the tail advances.
  - Pointers wrap modulo max_pending.
- Read data: s_readdata is broadcast to m0_readdata and m1_readdata.
- Unexpected valid: s_readdatavalid while the FIFO is empty drives no master valid and sets err_o = 1. err_o clears only on reset.
- Reset (rst_n_i = 0, asynchronous, including mid-operation):
  - FIFO emptied; pending_o = 0; err_o = 0; last_grant = 1, so master 0 wins the first tie.
  - Reads in flight are forgotten; the slave is reset on the same net.
  - While in reset: all mN_readdatavalid = 0, s_read = s_write = 0, both mN_waitrequest = 1.
- Latency: zero added cycles on the command path and zero on the response path.

Test Plan:
1. Single master, single read.
   - Stimulus: after reset, m0 writes 0xA5A5_0001 to address 5, then reads address 5.
   - Response: m0_waitrequest = 0 on both; one cycle later m0_readdatavalid = 1 with m0_readdata = 0xA5A5_0001; m1_readdatavalid = 0.
2. Round-robin tie.
   - Stimulus: m0 and m1 both hold reads from cycle 0, addresses 1 and 2.
   - Response: order of acceptance is m0, m1, m0, m1; each data beat returns to the master that issued it; pending_o never exceeds 2.
3. Fixed priority.
   - Stimulus: fixed_prio=1, both masters hold writes continuously for 4 cycles.
   - Response: m1_waitrequest = 1 for all 4 cycles; all 4 writes come from m0.
4. FIFO full.
   - Stimulus: max_pending=4, a slave model delays readdatavalid 6 cycles, m1 issues 5 back-to-back reads.
   - Response: the 5th read is stalled with waitrequest = 1 until the first pop; meanwhile an m0 write is accepted; pending_o peaks at 4.
5. Unexpected valid.
   - Stimulus: pulse s_readdatavalid with no outstanding read.
   - Response: err_o = 1 and stays 1; neither master sees readdatavalid; err_o returns to 0 only after rst_n_i pulses low.
6. Reset mid-operation.
   - Stimulus: assert rst_n_i = 0 with 3 reads pending.
   - Response: pending_o = 0 immediately (asynchronously); both waitrequests = 1 during reset; after release, the first tie grants m0.
